playlist_ctrl: RTL and testbench

Parametrised song-player control unit for the player piano: selects one of `NUM_SONGS` stored songs, runs the play/pause/wait state machine, and pulses `reset_player` to the song player whenever playback must restart. It adds configurable song count, play-mode handling (wrap, repeat-one, stop-at-end), and hold-to-scroll auto-repeat on the next/prev buttons. It sits between the front-panel button conditioning and the song player, and is gated by the top-level `master_state`.

---
 rtl/playlist_ctrl_if.sv | 26 ++
 rtl/playlist_ctrl.sv | 173 +++++++++++++++++
 tb/tb_playlist_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/playlist_ctrl_if.sv
// Front-panel / song-player bundle for playlist_ctrl.
// master: the side driving the controls (front panel, top level, song player).
// slave:  the playlist controller itself.
interface playlist_ctrl_if #(
  parameter int unsigned SONG_W = 2
);
  logic [1:0]        master_state;
  logic              play_button;
  logic              next_button;
  logic              prev_button;
  logic              song_done;
  logic [1:0]        mode;
  logic              play;
  logic              reset_player;
  logic [SONG_W-1:0] song;

  modport master (
    output master_state, play_button, next_button, prev_button, song_done, mode,
    input  play, reset_player, song
  );

  modport slave (
    input  master_state, play_button, next_button, prev_button, song_done, mode,
    output play, reset_player, song
  );
endinterface

// File: rtl/playlist_ctrl.sv
// Song-player control unit: song selection, play/pause/wait FSM and
// player restart pulses, with hold-to-scroll on next/prev.
// Optional feature macro: PLAYLIST_AUTOPLAY_EN -- a song_done that advances
// to a new song keeps playing instead of stopping in WAIT.
module playlist_ctrl #(
  parameter int unsigned NUM_SONGS     = 4,
  parameter int unsigned SONG_W        = 2,
  parameter int unsigned HOLD_CYCLES   = 8,
  parameter int unsigned REPEAT_CYCLES = 4
) (
  input  logic           clk,
  input  logic           reset,
  playlist_ctrl_if.slave bus
);

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [SONG_W-1:0] LAST_SONG   = SONG_W'(NUM_SONGS - 1);
  localparam logic [1:0]        MS_PLAYER   = 2'b10;
  localparam logic [1:0]        MODE_REPEAT = 2'b01;
  localparam logic [1:0]        MODE_STOP   = 2'b10;
  localparam logic [CNT_W-1:0]  CNT_HOLD    = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_REP     = CNT_W'(REPEAT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_SAT     = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);

`ifdef PLAYLIST_AUTOPLAY_EN
  localparam bit AUTOPLAY = 1'b1;
`else
  localparam bit AUTOPLAY = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PLAY, S_PAUSE} state_t;

  state_t            state_q, state_d;
  logic [SONG_W-1:0] song_q, song_d;
  logic              play_q, pulse_q, pulse_d;
  logic              play_prev_q, next_prev_q, prev_prev_q;
  // Counter value 0 means "not armed": auto-repeat only after a fresh edge.
  logic [CNT_W-1:0]  next_cnt_q, prev_cnt_q;
  logic              next_rep_q, prev_rep_q;

  logic              active_c, both_c, play_edge_c, next_tick_c, prev_tick_c;
  logic              step_up_c, step_dn_c, step_c, step_chg_c, stop_c;
  logic [SONG_W-1:0] up_tgt_c, dn_tgt_c, step_tgt_c, done_tgt_c;

  assign active_c    = (bus.master_state == MS_PLAYER);
  assign both_c      = bus.next_button && bus.prev_button;
  assign play_edge_c = bus.play_button && !play_prev_q;
  assign stop_c      = (bus.mode == MODE_STOP);
  assign next_tick_c = (next_cnt_q != '0) && (next_cnt_q == (next_rep_q ? CNT_REP : CNT_HOLD));
  assign prev_tick_c = (prev_cnt_q != '0) && (prev_cnt_q == (prev_rep_q ? CNT_REP : CNT_HOLD));
  assign step_up_c   = bus.next_button && !bus.prev_button && (!next_prev_q || next_tick_c);
  assign step_dn_c   = bus.prev_button && !bus.next_button && (!prev_prev_q || prev_tick_c);
  assign step_c      = step_up_c || step_dn_c;

  // Step and song_done targets: modulo for wrap modes, clamp for stop-at-end.
  assign up_tgt_c   = (song_q == LAST_SONG) ? (stop_c ? song_q : '0) : song_q + SONG_W'(1);
  assign dn_tgt_c   = (song_q == '0) ? (stop_c ? song_q : LAST_SONG) : song_q - SONG_W'(1);
  assign step_tgt_c = step_up_c ? up_tgt_c : dn_tgt_c;
  assign step_chg_c = (step_tgt_c != song_q);
  assign done_tgt_c = (bus.mode == MODE_REPEAT) ? song_q : up_tgt_c;

  // Button edge registers and hold/repeat counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      play_prev_q <= 1'b0;
      next_prev_q <= 1'b0;
      prev_prev_q <= 1'b0;
      next_cnt_q  <= '0;
      next_rep_q  <= 1'b0;
      prev_cnt_q  <= '0;
      prev_rep_q  <= 1'b0;
    end else begin
      play_prev_q <= bus.play_button;
      next_prev_q <= bus.next_button;
      prev_prev_q <= bus.prev_button;
      if (!active_c || both_c || !bus.next_button) begin
        next_cnt_q <= '0;
        next_rep_q <= 1'b0;
      end else if (!next_prev_q) begin
        next_cnt_q <= CNT_ONE;
        next_rep_q <= 1'b0;
      end else if (next_tick_c) begin
        next_cnt_q <= CNT_ONE;
        next_rep_q <= 1'b1;
      end else if (next_cnt_q != '0 && next_cnt_q != CNT_SAT) begin
        next_cnt_q <= next_cnt_q + CNT_ONE;
      end
      if (!active_c || both_c || !bus.prev_button) begin
        prev_cnt_q <= '0;
        prev_rep_q <= 1'b0;
      end else if (!prev_prev_q) begin
        prev_cnt_q <= CNT_ONE;
        prev_rep_q <= 1'b0;
      end else if (prev_tick_c) begin
        prev_cnt_q <= CNT_ONE;
        prev_rep_q <= 1'b1;
      end else if (prev_cnt_q != '0 && prev_cnt_q != CNT_SAT) begin
        prev_cnt_q <= prev_cnt_q + CNT_ONE;
      end
    end
  end

  // State register with registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      song_q  <= '0;
      play_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      song_q  <= song_d;
      play_q  <= (state_d == S_PLAY);
      pulse_q <= pulse_d;
    end
  end

  // Next state, next song and restart pulse.
  always_comb begin
    state_d = state_q;
    song_d  = song_q;
    pulse_d = 1'b0;
    if (!active_c) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_WAIT;
        S_WAIT: begin
          if (step_c) begin
            song_d  = step_tgt_c;
            pulse_d = step_chg_c;
          end else if (play_edge_c) begin
            state_d = S_PLAY;
          end
        end
        S_PLAY: begin
          if (step_c) begin
            song_d  = step_tgt_c;
            pulse_d = step_chg_c;
            state_d = S_WAIT;
          end else if (bus.song_done) begin
            song_d  = done_tgt_c;
            pulse_d = 1'b1;
            if (bus.mode == MODE_REPEAT || (AUTOPLAY && done_tgt_c != song_q)) begin
              state_d = S_PLAY;
            end else begin
              state_d = S_WAIT;
            end
          end else if (play_edge_c) begin
            state_d = S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (step_c) begin
            song_d  = step_tgt_c;
            pulse_d = step_chg_c;
            state_d = S_WAIT;
          end else if (play_edge_c) begin
            state_d = S_PLAY;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.play         = play_q;
  assign bus.reset_player = pulse_q;
  assign bus.song         = song_q;

endmodule

// File: tb/tb_playlist_ctrl.sv
// Self-checking bench for playlist_ctrl (NUM_SONGS=5): directed scenarios
// followed by random button/event segments, all compared every cycle
// against a behavioural model of the playlist rules.
module tb_playlist_ctrl;

  localparam int N      = 5;
  localparam int SW     = 3;
  localparam int HOLD   = 8;
  localparam int REP    = 4;
`ifdef PLAYLIST_AUTOPLAY_EN
  localparam bit AUTOPLAY = 1'b1;
`else
  localparam bit AUTOPLAY = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  playlist_ctrl_if #(.SONG_W(SW)) bus ();

  playlist_ctrl #(
    .NUM_SONGS(N), .SONG_W(SW), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model
  typedef enum int {M_IDLE, M_WAIT, M_PLAY, M_PAUSE} mstate_t;
  mstate_t m_st;
  int m_song;
  bit m_pulse;
  bit h_play, h_next, h_prev;
  int t_next, t_prev;   // cycles since the press edge, -1 = no auto-repeat

  function automatic bit is_step(input int t);
    return (t == 0) || (t >= HOLD && ((t - HOLD) % REP) == 0);
  endfunction

  task automatic model_step();
    bit pe, up, dn, stop, step;
    int raw, tgt;
    if (!reset) begin
      m_st = M_IDLE; m_song = 0; m_pulse = 0;
      h_play = 0; h_next = 0; h_prev = 0; t_next = -1; t_prev = -1;
      return;
    end
    pe = bus.play_button && !h_play;
    if (bus.master_state != 2'b10 || (bus.next_button && bus.prev_button)) begin
      t_next = -1; t_prev = -1;
    end else begin
      t_next = !bus.next_button ? -1 : (!h_next ? 0 : (t_next < 0 ? -1 : t_next + 1));
      t_prev = !bus.prev_button ? -1 : (!h_prev ? 0 : (t_prev < 0 ? -1 : t_prev + 1));
    end
    up = (t_next >= 0) && is_step(t_next);
    dn = (t_prev >= 0) && is_step(t_prev);
    step = up || dn;
    h_play = bus.play_button; h_next = bus.next_button; h_prev = bus.prev_button;
    stop = (bus.mode == 2'b10);
    raw = m_song + (up ? 1 : -1);
    if (stop) tgt = (raw < 0 || raw >= N) ? m_song : raw;
    else      tgt = (raw + N) % N;
    m_pulse = 0;
    if (bus.master_state != 2'b10) begin
      m_st = M_IDLE;
    end else begin
      case (m_st)
        M_IDLE: m_st = M_WAIT;
        M_WAIT: begin
          if (step) begin m_pulse = (tgt != m_song); m_song = tgt; end
          else if (pe) m_st = M_PLAY;
        end
        M_PLAY: begin
          if (step) begin
            m_pulse = (tgt != m_song); m_song = tgt; m_st = M_WAIT;
          end else if (bus.song_done) begin
            m_pulse = 1;
            if (bus.mode == 2'b01) begin
              m_st = M_PLAY;
            end else if (stop && m_song == N - 1) begin
              m_st = M_WAIT;
            end else begin
              m_song = (m_song + 1) % N;
              m_st = AUTOPLAY ? M_PLAY : M_WAIT;
            end
          end else if (pe) m_st = M_PAUSE;
        end
        M_PAUSE: begin
          if (step) begin m_pulse = (tgt != m_song); m_song = tgt; m_st = M_WAIT; end
          else if (pe) m_st = M_PLAY;
        end
        default: m_st = M_IDLE;
      endcase
    end
  endtask

  // One clock: model consumes the sampled inputs, outputs compared 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("play", int'(bus.play), int'(m_st == M_PLAY));
    check("reset_player", int'(bus.reset_player), int'(m_pulse));
    check("song", int'(bus.song), m_song);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic tap_play();
    bus.play_button = 1'b1; cycle(); bus.play_button = 1'b0; cycle();
  endtask

  task automatic tap_next();
    bus.next_button = 1'b1; cycle(); bus.next_button = 1'b0; cycle();
  endtask

  task automatic tap_prev();
    bus.prev_button = 1'b1; cycle(); bus.prev_button = 1'b0; cycle();
  endtask

  int pulses[$];

  initial begin
    reset = 1'b0;
    bus.master_state = 2'b00;
    bus.play_button = 0; bus.next_button = 0; bus.prev_button = 0;
    bus.song_done = 0; bus.mode = 2'b00;

    // Reset and gating
    run(2);
    check("rst_play", int'(bus.play), 0);
    check("rst_song", int'(bus.song), 0);
    check("rst_pulse", int'(bus.reset_player), 0);
    reset = 1'b1;
    bus.master_state = 2'b10;
    run(2);
    bus.play_button = 1'b1; cycle();
    check("play_after_edge", int'(bus.play), 1);
    bus.play_button = 1'b0; cycle();
    bus.master_state = 2'b00; cycle();
    check("gated_play", int'(bus.play), 0);
    bus.master_state = 2'b10; run(2);

    // Auto-repeat from song 3 in WRAP
    tap_next(); tap_next(); tap_next();
    check("song_before_hold", int'(bus.song), 3);
    bus.next_button = 1'b1;
    for (int i = 0; i < 19; i++) begin
      if (i == 17) bus.next_button = 1'b0;
      cycle();
      if (bus.reset_player) pulses.push_back(int'(bus.song));
    end
    check("hold_steps", pulses.size(), 4);
    if (pulses.size() == 4) begin
      check("hold_s0", pulses[0], 4);
      check("hold_s1", pulses[1], 0);
      check("hold_s2", pulses[2], 1);
      check("hold_s3", pulses[3], 2);
    end

    // STOP_AT_END clamp and last-song done
    bus.mode = 2'b10;
    tap_prev(); tap_prev();
    bus.prev_button = 1'b1; cycle();
    check("clamp_song", int'(bus.song), 0);
    check("clamp_pulse", int'(bus.reset_player), 0);
    bus.prev_button = 1'b0; cycle();
    tap_next(); tap_next(); tap_next(); tap_next();
    tap_play();
    bus.song_done = 1'b1; cycle(); bus.song_done = 1'b0;
    check("stop_last_song", int'(bus.song), N - 1);
    check("stop_last_pulse", int'(bus.reset_player), 1);
    check("stop_last_play", int'(bus.play), 0);
    cycle();

    // REPEAT_ONE at song 2
    bus.mode = 2'b01;
    tap_next(); tap_next(); tap_next();
    tap_play();
    bus.song_done = 1'b1; cycle(); bus.song_done = 1'b0;
    check("rep_song", int'(bus.song), 2);
    check("rep_pulse", int'(bus.reset_player), 1);
    check("rep_play", int'(bus.play), 1);
    cycle();

    // Simultaneous events: step beats song_done, next+prev is no step
    bus.mode = 2'b00;
    tap_prev();
    tap_play();
    bus.next_button = 1'b1; bus.song_done = 1'b1; cycle();
    bus.next_button = 1'b0; bus.song_done = 1'b0;
    check("sim_song", int'(bus.song), 2);
    check("sim_play", int'(bus.play), 0);
    cycle();
    bus.next_button = 1'b1; bus.prev_button = 1'b1; run(3);
    check("both_song", int'(bus.song), 2);
    bus.next_button = 1'b0; bus.prev_button = 1'b0; cycle();

    // Pause path, then song_done in WRAP
    tap_play();
    bus.play_button = 1'b1; cycle(); bus.play_button = 1'b0;
    check("pause_play", int'(bus.play), 0);
    cycle();
    bus.next_button = 1'b1; cycle(); bus.next_button = 1'b0;
    check("pause_next_song", int'(bus.song), 3);
    check("pause_next_pulse", int'(bus.reset_player), 1);
    cycle();
    tap_play();
    bus.song_done = 1'b1; cycle(); bus.song_done = 1'b0;
    check("done_wrap_song", int'(bus.song), 4);
    check("done_wrap_play", int'(bus.play), int'(AUTOPLAY));
    cycle();

    // Random segments
    for (int s = 0; s < 300; s++) begin
      int kind, len;
      kind = int'($urandom_range(0, 13));
      len  = int'($urandom_range(1, 25));
      case (kind)
        0: run(len % 5 + 1);
        1, 2: begin bus.next_button = 1'b1; run(len); bus.next_button = 1'b0; cycle(); end
        3: begin bus.prev_button = 1'b1; run(len); bus.prev_button = 1'b0; cycle(); end
        4: begin
          bus.next_button = 1'b1; bus.prev_button = 1'b1; run(len % 5 + 1);
          bus.next_button = 1'b0; bus.prev_button = 1'b0; cycle();
        end
        5, 6, 7: tap_play();
        8, 9: begin bus.song_done = 1'b1; cycle(); bus.song_done = 1'b0; cycle(); end
        10: begin
          bus.next_button = 1'b1; bus.song_done = 1'b1; cycle();
          bus.next_button = 1'b0; bus.song_done = 1'b0; cycle();
        end
        11: bus.mode = 2'($urandom_range(0, 3));
        12: begin
          bus.master_state = 2'($urandom_range(0, 2));
          run(len % 3 + 1);
          bus.master_state = 2'b10; run(2);
        end
        default: begin
          if (len < 4) begin reset = 1'b0; cycle(); reset = 1'b1; cycle(); end
          else run(1);
        end
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
